// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter for the shared 16-bit barrel shifter: two requesters, one
// operation in flight, operands registered onto the shifter bus, result returned per port.

module shift_unit_arbiter_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] yout,
    output logic          valid,
    output logic [DW-1:0] data
);
    // data is deliberately kept after valid drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= yout;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end
endmodule

module shift_unit_arbiter #(
    parameter int DW = 16,
    parameter int BW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    input  logic          req0_rotate,
    input  logic          req0_sra,
    output logic          resp0_valid,
    input  logic          resp0_ready,
    output logic [DW-1:0] resp0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    input  logic          req1_rotate,
    input  logic          req1_sra,
    output logic          resp1_valid,
    input  logic          resp1_ready,
    output logic [DW-1:0] resp1_data,
    output logic [DW-1:0] sh_ain,
    output logic [BW-1:0] sh_bin,
    output logic          sh_rotate,
    output logic          sh_sra,
    input  logic [DW-1:0] sh_yout,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nx;
    logic              ptr;
    logic              any_req, winner, grant;
    logic [1:0]        resp_rdy, resp_vld;
    logic [1:0][DW-1:0] resp_dat;

    assign any_req = req0_valid | req1_valid;
    // contention is settled by the pointer; otherwise the lone requester wins
    assign winner  = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign grant   = (state == IDLE) & any_req;

    // gated by rst_n so no ready can leak out while reset is held
    assign req0_ready = rst_n & grant & ~winner;
    assign req1_ready = rst_n & grant & winner;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (resp_rdy[owner]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            sh_ain    <= '0;
            sh_bin    <= '0;
            sh_rotate <= 1'b0;
            sh_sra    <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner     <= winner;
                ptr       <= ~winner;
                sh_ain    <= winner ? req1_a      : req0_a;
                sh_bin    <= winner ? req1_b      : req0_b;
                sh_rotate <= winner ? req1_rotate : req0_rotate;
                sh_sra    <= winner ? req1_sra    : req0_sra;
            end
        end
    end

    assign resp_rdy = {resp1_ready, resp0_ready};

    for (genvar i = 0; i < 2; i++) begin : g_lane
        shift_unit_arbiter_lane #(.DW(DW)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  ((state == EXEC) && (owner == 1'(i))),
            .clear ((state == RESP) && (owner == 1'(i)) && resp_rdy[i]),
            .yout  (sh_yout),
            .valid (resp_vld[i]),
            .data  (resp_dat[i])
        );
    end

    assign resp0_valid = resp_vld[0];
    assign resp1_valid = resp_vld[1];
    assign resp0_data  = resp_dat[0];
    assign resp1_data  = resp_dat[1];
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with a behavioural shifter on the sh_* bus.

module tb_shift_unit_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_rotate, req0_sra;
    logic [15:0] req0_a;
    logic [4:0]  req0_b;
    logic        resp0_valid, resp0_ready;
    logic [15:0] resp0_data;
    logic        req1_valid, req1_ready, req1_rotate, req1_sra;
    logic [15:0] req1_a;
    logic [4:0]  req1_b;
    logic        resp1_valid, resp1_ready;
    logic [15:0] resp1_data;
    logic [15:0] sh_ain, sh_yout;
    logic [4:0]  sh_bin;
    logic        sh_rotate, sh_sra, busy, owner;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.DW(16), .BW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_rotate(req0_rotate), .req0_sra(req0_sra),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_rotate(req1_rotate), .req1_sra(req1_sra),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .sh_ain(sh_ain), .sh_bin(sh_bin), .sh_rotate(sh_rotate), .sh_sra(sh_sra),
        .sh_yout(sh_yout), .busy(busy), .owner(owner)
    );

    // external shifter: positive b shifts right, negative b shifts left by -b
    function automatic logic [15:0] shifter(logic [15:0] a, logic [4:0] b, logic rot, logic sra);
        int          amt;
        logic [31:0] d;
        if (b[4]) begin
            amt = 32 - int'(b);
            d   = rot ? ({a, a} << amt) : ({16'h0, a} << amt);
            return rot ? d[31:16] : d[15:0];
        end
        amt = int'(b);
        if (rot) begin
            d = {a, a} >> amt;
            return d[15:0];
        end
        if (sra) return 16'($signed(a) >>> amt);
        return a >> amt;
    endfunction

    always_comb sh_yout = shifter(sh_ain, sh_bin, sh_rotate, sh_sra);

    typedef struct {
        int          port;
        logic [15:0] a;
        logic [4:0]  b;
        logic        rot;
        logic        sra;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(int p, logic v, logic [15:0] a, logic [4:0] b, logic rot, logic sra);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_rotate = rot; req0_sra = sra;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_rotate = rot; req1_sra = sra;
        end
    endtask

    function automatic logic [60:0] all_outs();
        return {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data,
                sh_ain, sh_bin, sh_rotate, sh_sra, busy, owner};
    endfunction

    task automatic run_op(vec_t v);
        @(negedge clk);
        set_req(v.port, 1'b1, v.a, v.b, v.rot, v.sra);
        #1 chk("grant", {req1_ready, req0_ready}, (v.port == 1) ? 2'b10 : 2'b01);
        @(negedge clk);
        set_req(v.port, 1'b0, v.a, v.b, v.rot, v.sra);
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_owner", owner, v.port[0]);
        chk("sh_ain", sh_ain, v.a);
        chk("sh_bin/rot/sra", {sh_bin, sh_rotate, sh_sra}, {v.b, v.rot, v.sra});
        chk("exec_no_resp", {resp1_valid, resp0_valid}, 2'b00);
        @(negedge clk);
        #1;
        chk("resp_valid", {resp1_valid, resp0_valid}, (v.port == 1) ? 2'b10 : 2'b01);
        chk("resp_data", (v.port == 1) ? resp1_data : resp0_data, v.exp);
        if (v.port == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("done_idle", {busy, resp1_valid, resp0_valid}, 3'b000);
        chk("data_hold", (v.port == 1) ? resp1_data : resp0_data, v.exp);
        chk("sh_hold", sh_ain, v.a);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        int k, last, cyc;
        vecs[0] = '{0, 16'h0FD6, 5'd6,     1'b0, 1'b0, 16'h003F};
        vecs[1] = '{1, 16'hCFD6, 5'd6,     1'b0, 1'b1, 16'hFF3F};
        vecs[2] = '{1, 16'h0FD6, 5'd6,     1'b1, 1'b0, 16'h583F};
        vecs[3] = '{1, 16'h0FD6, 5'b11010, 1'b0, 1'b0, 16'hF580};
        vecs[4] = '{0, 16'h0FD6, 5'd0,     1'b0, 1'b0, 16'h0FD6};
        vecs[5] = '{0, 16'h0FD6, 5'b10000, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{0, 16'hCFD6, 5'b10000, 1'b1, 1'b0, 16'hCFD6};
        vecs[7] = '{1, 16'h8001, 5'b11111, 1'b1, 1'b0, 16'h0003};
        vecs[8] = '{0, 16'h8000, 5'd15,    1'b0, 1'b1, 16'hFFFF};

        rst_n = 1'b0;
        set_req(0, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", 64'(all_outs()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // backpressure on port 0 with port 1 pending
        @(negedge clk);
        set_req(0, 1'b1, 16'h0FD6, 5'd6, 1'b0, 1'b0);
        #1 chk("bp_grant0", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        set_req(0, 1'b0, 16'h0FD6, 5'd6, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'hCFD6, 5'd6, 1'b0, 1'b1);
        #1 chk("bp_exec_no_ready", {req1_ready, req0_ready}, 2'b00);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", {resp0_valid, resp0_data, busy, req1_ready, resp1_valid},
                {1'b1, 16'h003F, 1'b1, 1'b0, 1'b0});
            @(negedge clk);
        end
        resp0_ready = 1'b1;
        req0_valid  = 1'b1;
        #1 chk("bp_release_no_ready", {req1_ready, req0_ready}, 2'b00);
        @(negedge clk);
        resp0_ready = 1'b0;
        #1 chk("bp_ptr_grant1", {req1_ready, req0_ready}, 2'b10);
        req0_valid = 1'b0;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1 chk("bp_resp1", {resp1_valid, resp1_data, resp0_valid}, {1'b1, 16'hFF3F, 1'b0});
        resp1_ready = 1'b1;
        @(negedge clk);
        resp1_ready = 1'b0;

        // reset during EXEC, pointer was pushed toward port 1
        set_req(0, 1'b1, 16'hCFD6, 5'd6, 1'b0, 1'b1);
        #1 chk("rst_grant0", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        #1 chk("rst_in_exec", {busy, owner}, 2'b10);
        rst_n      = 1'b0;
        req1_valid = 1'b1;
        #1 chk("rst_midop_outputs", 64'(all_outs()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ptr_port0", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        #1 chk("rst_reissue_resp", {resp0_valid, resp0_data}, {1'b1, 16'hFF3F});
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;

        // both ports requesting continuously from reset
        rst_n = 1'b0;
        set_req(0, 1'b1, 16'h0FD6, 5'd6, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'hCFD6, 5'd6, 1'b0, 1'b1);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0; last = 0;
        for (cyc = 0; cyc < 14; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("rr_order", {req1_ready, req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
                if (k > 0) chk("rr_interval", 64'(cyc - last), 64'd3);
                last = cyc;
                k++;
            end
            if (resp0_valid) chk("rr_resp0", {resp1_valid, owner, resp0_data}, {1'b0, 1'b0, 16'h003F});
            if (resp1_valid) chk("rr_resp1", {resp0_valid, owner, resp1_data}, {1'b0, 1'b1, 16'hFF3F});
            @(negedge clk);
        end
        chk("rr_grant_count", 64'(k), 64'd5);
        set_req(0, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
